// File: rtl/song_pkg.sv
// Shared types and widths for the song reader: mode encodings, note word layout, FSM states.
// No logic of its own; imported by song_rom and song_reader.
package song_pkg;

    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;
    localparam int WORD_W = NOTE_W + DUR_W;
    localparam int IDX_W  = 5;
    localparam int SONG_W = 2;
    localparam int ADDR_W = SONG_W + IDX_W;

    typedef enum logic [1:0] {
        JAM_SESH    = 2'b00,
        COMPOSER    = 2'b01,
        SONG_PLAYER = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FETCH      = 3'd1,
        S_ROM_WAIT   = 3'd2,
        S_WAIT_AVAIL = 3'd3,
        S_WAIT_LOW   = 3'd4,
        S_DONE       = 3'd5
    } fsm_t;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  dur;
    } note_word_t;

    // An all-zero word terminates a song; a zero note with nonzero duration is a rest.
    function automatic logic is_end_word(input logic [WORD_W-1:0] w);
        return w == '0;
    endfunction

endpackage

// File: rtl/song_rom.sv
// Song ROM: 4 songs x 32 notes of {note, duration}, addressed by {song, index}.
// Latency: one cycle (registered read data). No backpressure; reads every cycle.
module song_rom
    import song_pkg::*;
(
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [WORD_W-1:0] data
);

    note_word_t word;

    always_comb begin
        word = '0;
        case (addr[ADDR_W-1:IDX_W])
            2'd0: begin
                case (addr[IDX_W-1:0])
                    5'd0:    word = '{note: 6'd10, dur: 6'd2};
                    5'd1:    word = '{note: 6'd12, dur: 6'd1};
                    5'd2:    word = '{note: 6'd0,  dur: 6'd2};
                    5'd3:    word = '{note: 6'd15, dur: 6'd3};
                    5'd4:    word = '{note: 6'd17, dur: 6'd1};
                    default: word = '0;
                endcase
            end
            2'd1: begin
                case (addr[IDX_W-1:0])
                    5'd0:    word = '{note: 6'd20, dur: 6'd1};
                    5'd1:    word = '{note: 6'd22, dur: 6'd2};
                    5'd2:    word = '{note: 6'd24, dur: 6'd1};
                    default: word = '0;
                endcase
            end
            // Song 2 fills all 32 slots: a rising scale with no terminator.
            2'd2: begin
                word.note = {1'b0, addr[IDX_W-1:0]} + 6'd1;
                word.dur  = 6'd1;
            end
            default: begin
                case (addr[IDX_W-1:0])
                    5'd0:    word = '{note: 6'd40, dur: 6'd2};
                    default: word = '0;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        data <= word;
    end

endmodule

// File: rtl/song_reader.sv
// Song reader: walks the song ROM and hands one note at a time to the note player.
// Latency: first strobe 4 cycles after play is sampled; holds in WAIT_AVAIL while available/play low.
module song_reader
    import song_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic [1:0]        state,
    input  logic              next_song,
    input  logic              available,
    output logic [WORD_W-1:0] next_song_note,
    output logic              load_new_note,
    output logic              song_done,
    output logic [IDX_W-1:0]  note_index,
    output logic [SONG_W-1:0] current_song
);

    fsm_t              fsm_q, fsm_d;
    logic [WORD_W-1:0] note_q, note_d;
    logic              load_q, load_d;
    logic              done_q, done_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SONG_W-1:0] song_q, song_d;
    logic [WORD_W-1:0] rom_dat;

    song_rom u_rom (
        .clk  (clk),
        .addr ({song_q, idx_q}),
        .data (rom_dat)
    );

    always_comb begin
        fsm_d  = fsm_q;
        note_d = note_q;
        load_d = 1'b0;
        done_d = done_q;
        idx_d  = idx_q;
        song_d = song_q;
        if (state != SONG_PLAYER) begin
            fsm_d  = S_IDLE;
            idx_d  = '0;
            done_d = 1'b0;
        end else if (next_song) begin
            song_d = song_q + SONG_W'(1);
            if (fsm_q != S_IDLE) begin
                fsm_d  = S_FETCH;
                idx_d  = '0;
                done_d = 1'b0;
            end
        end else if (play) begin
            case (fsm_q)
                S_IDLE:     fsm_d = S_FETCH;
                S_FETCH:    fsm_d = S_ROM_WAIT;
                S_ROM_WAIT: begin
                    note_d = rom_dat;
                    if (is_end_word(rom_dat)) begin
                        fsm_d  = S_DONE;
                        done_d = 1'b1;
                    end else begin
                        fsm_d = S_WAIT_AVAIL;
                    end
                end
                S_WAIT_AVAIL: begin
                    if (available) begin
                        load_d = 1'b1;
                        fsm_d  = S_WAIT_LOW;
                    end
                end
                // Only advance once the player has dropped available for the note just sent.
                S_WAIT_LOW: begin
                    if (!available) begin
                        if (&idx_q) begin
                            fsm_d  = S_DONE;
                            done_d = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                            fsm_d = S_FETCH;
                        end
                    end
                end
                S_DONE:  fsm_d = S_DONE;
                default: fsm_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q  <= S_IDLE;
            note_q <= '0;
            load_q <= 1'b0;
            done_q <= 1'b0;
            idx_q  <= '0;
            song_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            note_q <= note_d;
            load_q <= load_d;
            done_q <= done_d;
            idx_q  <= idx_d;
            song_q <= song_d;
        end
    end

    assign next_song_note = note_q;
    assign load_new_note  = load_q;
    assign song_done      = done_q;
    assign note_index     = idx_q;
    assign current_song   = song_q;

endmodule

// File: tb/tb_song_reader.sv
// Directed bench for song_reader with a simple note-player model driving available.
// Expected ROM contents and timing are hand-written constants.
module tb_song_reader;

    logic        clk;
    logic        reset;
    logic        play;
    logic [1:0]  state;
    logic        next_song;
    logic        available;
    logic [11:0] next_song_note;
    logic        load_new_note;
    logic        song_done;
    logic [4:0]  note_index;
    logic [1:0]  current_song;

    int n_checks = 0;
    int n_fail   = 0;

    song_reader dut (
        .clk            (clk),
        .reset          (reset),
        .play           (play),
        .state          (state),
        .next_song      (next_song),
        .available      (available),
        .next_song_note (next_song_note),
        .load_new_note  (load_new_note),
        .song_done      (song_done),
        .note_index     (note_index),
        .current_song   (current_song)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_next();
        next_song = 1'b1;
        tick();
        next_song = 1'b0;
    endtask

    task automatic count_loads(input int n, output int loads);
        loads = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (load_new_note) loads++;
        end
    endtask

    function automatic logic [11:0] exp_word(input int song, input int idx);
        logic [5:0] n;
        exp_word = 12'h000;
        case (song)
            0: case (idx)
                   0: exp_word = 12'h282;
                   1: exp_word = 12'h301;
                   2: exp_word = 12'h002;
                   3: exp_word = 12'h3C3;
                   4: exp_word = 12'h441;
                   default: exp_word = 12'h000;
               endcase
            1: case (idx)
                   0: exp_word = 12'h501;
                   1: exp_word = 12'h582;
                   2: exp_word = 12'h601;
                   default: exp_word = 12'h000;
               endcase
            2: begin
                   n = 6'(idx + 1);
                   exp_word = {n, 6'd1};
               end
            default: case (idx)
                   0: exp_word = 12'hA02;
                   default: exp_word = 12'h000;
               endcase
        endcase
    endfunction

    // Player model: available drops one cycle after a strobe, returns after 'duration' beats.
    task automatic run_song(input int song, input int max_strobes, input int budget,
                            output int got, output int first_cyc);
        int          cnt;
        int          beats;
        int          cur_dur;
        bit          drop;
        logic [11:0] w;
        cnt = 0; beats = 0; cur_dur = 0; drop = 1'b0; first_cyc = -1;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (drop) begin
                available = 1'b0;
                beats     = cur_dur;
                drop      = 1'b0;
            end else if (!available) begin
                beats--;
                if (beats <= 0) available = 1'b1;
            end
            if (load_new_note) begin
                if (first_cyc < 0) first_cyc = c + 1;
                w = exp_word(song, cnt);
                check("strobe_index", 32'(note_index), 32'(cnt));
                check("strobe_word", 32'(next_song_note), 32'(w));
                cur_dur = int'(w[5:0]);
                cnt++;
                drop = 1'b1;
                if (cnt == max_strobes) break;
            end
            if (song_done) break;
        end
        available = 1'b1;
        got = cnt;
    endtask

    initial begin
        int n;
        int first;
        int loads;

        reset = 1'b1; play = 1'b0; state = 2'b11; next_song = 1'b0; available = 1'b1;
        tick();
        tick();
        check("rst_note", 32'(next_song_note), 32'h000);
        check("rst_load", 32'(load_new_note), 0);
        check("rst_done", 32'(song_done), 0);
        check("rst_index", 32'(note_index), 0);
        check("rst_song", 32'(current_song), 0);
        reset = 1'b0;
        tick();

        // next_song while idle: song advances, no fetch, wraps 3 -> 0
        pulse_next();
        check("idle_next_song", 32'(current_song), 1);
        pulse_next();
        pulse_next();
        pulse_next();
        check("idle_song_wrap", 32'(current_song), 0);
        count_loads(5, loads);
        check("idle_no_strobe", 32'(loads), 0);

        // song 0: five notes then terminator
        play = 1'b1;
        run_song(0, 99, 400, n, first);
        check("first_strobe_cycle", 32'(first), 4);
        check("song0_strobes", 32'(n), 5);
        check("song0_done", 32'(song_done), 1);
        count_loads(5, loads);
        check("done_no_strobe", 32'(loads), 0);
        check("done_held", 32'(song_done), 1);

        pulse_next();
        check("ns_song1", 32'(current_song), 1);
        check("ns_done_clr", 32'(song_done), 0);
        check("ns_index", 32'(note_index), 0);
        check("ns_no_load", 32'(load_new_note), 0);
        run_song(1, 99, 400, n, first);
        check("song1_first_cycle", 32'(first), 3);
        check("song1_strobes", 32'(n), 3);
        check("song1_done", 32'(song_done), 1);

        // song 2 has no terminator: 32 notes then done at index 31
        pulse_next();
        check("ns_song2", 32'(current_song), 2);
        run_song(2, 99, 1000, n, first);
        check("song2_strobes", 32'(n), 32);
        check("song2_done", 32'(song_done), 1);

        // pause in WAIT_AVAIL
        available = 1'b0;
        pulse_next();
        check("ns_song3", 32'(current_song), 3);
        tick(); tick(); tick();
        check("wa_no_load", 32'(load_new_note), 0);
        check("wa_word", 32'(next_song_note), 32'hA02);
        play = 1'b0;
        available = 1'b1;
        count_loads(20, loads);
        check("pause_no_strobe", 32'(loads), 0);
        check("pause_index", 32'(note_index), 0);
        play = 1'b1;
        tick();
        check("resume_strobe", 32'(load_new_note), 1);
        check("resume_word", 32'(next_song_note), 32'hA02);
        available = 1'b0;
        tick(); tick(); tick();
        available = 1'b1;
        check("song3_done", 32'(song_done), 1);
        pulse_next();
        check("song_wrap", 32'(current_song), 0);

        // leave SONG_PLAYER mid-song
        run_song(0, 2, 200, n, first);
        check("mid_strobes", 32'(n), 2);
        state = 2'b00;
        tick();
        check("jam_index", 32'(note_index), 0);
        check("jam_load", 32'(load_new_note), 0);
        check("jam_song", 32'(current_song), 0);
        count_loads(5, loads);
        check("jam_no_strobe", 32'(loads), 0);
        state = 2'b11;
        run_song(0, 1, 50, n, first);
        check("rejoin_first_cycle", 32'(first), 4);

        // next_song and available together in WAIT_AVAIL
        available = 1'b0;
        tick(); tick(); tick();
        check("wa2_index", 32'(note_index), 1);
        check("wa2_word", 32'(next_song_note), 32'h301);
        next_song = 1'b1;
        available = 1'b1;
        tick();
        next_song = 1'b0;
        check("ns_wins_load", 32'(load_new_note), 0);
        check("ns_wins_song", 32'(current_song), 1);
        check("ns_wins_index", 32'(note_index), 0);

        // async reset between edges while a strobe would be pending
        available = 1'b0;
        tick(); tick(); tick();
        next_song = 1'b1;
        available = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("arst_load", 32'(load_new_note), 0);
        check("arst_note", 32'(next_song_note), 32'h000);
        check("arst_index", 32'(note_index), 0);
        check("arst_song", 32'(current_song), 0);
        check("arst_done", 32'(song_done), 0);
        tick();
        check("arst_edge_load", 32'(load_new_note), 0);
        next_song = 1'b0;
        reset = 1'b0;
        run_song(0, 1, 50, n, first);
        check("post_rst_first_cycle", 32'(first), 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", n_checks, n_fail);
        $fatal(1);
    end

endmodule

// File: doc/song_reader.md
SONG_READER -- requirements
Module: song_reader

Interface
REQ-001 SHALL have port clk  input  1  sole clock, all state changes on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have port play  input  1  level; high permits note issue, low pauses.
REQ-004 SHALL have port state  input  2  system mode; 2'b00 JAM_SESH, 2'b01 COMPOSER, 2'b11 SONG_PLAYER; block active only in SONG_PLAYER.
REQ-005 SHALL have port next_song  input  1  single-cycle pulse; advance to next song, restart at note 0.
REQ-006 SHALL have port available  input  1  from note player; high = ready to accept a note.
REQ-007 SHALL have port next_song_note  output  12  {note[5:0], duration[5:0]} presented to note player.
REQ-008 SHALL have port load_new_note  output  1  single-cycle strobe; next_song_note valid in same cycle.
REQ-009 SHALL have port song_done  output  1  level; current song exhausted.
REQ-010 SHALL have port note_index  output  5  index of note currently fetched/issued.
REQ-011 SHALL have port current_song  output  2  selected song number.

Function
REQ-012 SHALL implement FSM states IDLE, FETCH, ROM_WAIT, WAIT_AVAIL, WAIT_LOW, DONE.
REQ-013 IDLE -> FETCH when play==1 and state==SONG_PLAYER, sampled on clock edge.
REQ-014 FETCH presents ROM address {current_song, note_index}; ROM has 1-cycle read latency; FETCH -> ROM_WAIT.
REQ-015 ROM_WAIT registers ROM word into next_song_note; if word==12'h000 -> DONE, else -> WAIT_AVAIL.
REQ-016 WAIT_AVAIL: when play==1 and available==1, assert load_new_note for exactly one cycle and -> WAIT_LOW; otherwise hold, no strobe.
REQ-017 First load_new_note SHALL be high in the 4th cycle after play sampled high in IDLE when available is already high (FETCH, ROM_WAIT, WAIT_AVAIL, strobe).
REQ-018 WAIT_LOW: wait until available==0, then increment note_index and -> FETCH; prevents double-load on a stale available.
REQ-019 note_index wrap 31 -> 0 SHALL instead -> DONE (32 notes max per song).
REQ-020 Note word with note==0 and duration!=0 is a rest and SHALL be issued normally.
REQ-021 DONE: song_done=1, no strobes; exit only via next_song, mode change, or reset.
REQ-022 next_song pulse in any non-IDLE state: current_song increments mod 4 (3 -> 0), note_index=0, song_done=0, -> FETCH; no strobe that cycle.
REQ-023 next_song coincident with available in WAIT_AVAIL: next_song wins, no load.
REQ-024 next_song in IDLE: current_song increments, remains IDLE.
REQ-025 state leaving SONG_PLAYER in any state: -> IDLE, note_index=0, song_done=0, current_song retained, load_new_note=0 that cycle.
REQ-026 play low mid-song: hold current state and note_index; resume without refetch.
REQ-027 All outputs SHALL be registered; no combinational path input -> output.

Reset
REQ-028 On reset: FSM=IDLE, next_song_note=12'h000, load_new_note=0, song_done=0, note_index=0, current_song=0.
REQ-029 Reset asserted mid-operation SHALL abort any pending strobe in that cycle; first post-reset strobe follows REQ-017.

Structure
REQ-030 Mode encodings, note/duration widths (6/6), index width (5), song-select width (2) and FSM encoding SHALL live in shared package song_pkg.
REQ-031 ROM SHALL be sub-module song_rom: 7-bit address, 12-bit synchronous read data, 128 words (4 songs x 32 notes).

Verification
REQ-032 Reset, state=SONG_PLAYER, play=1, available=1 -> load_new_note high exactly 4th cycle after play sampled, next_song_note = song_rom[0].
REQ-033 Note player model drops available 1 cycle after strobe, raises after duration beats -> one strobe per note, note_index 0,1,2... in order, never two strobes per note.
REQ-034 Song 0 word 5 = 12'h000 -> exactly 5 strobes, song_done=1 thereafter; next_song pulse -> current_song=1, song_done=0, strobe of song_rom[32].
REQ-035 play=0 during WAIT_AVAIL for 20 cycles with available=1 -> no strobe, note_index unchanged; play=1 -> strobe next cycle.
REQ-036 state -> JAM_SESH mid-song -> IDLE, note_index=0, no strobe; return to SONG_PLAYER -> restarts at note 0 of same song.
REQ-037 next_song and available both high in WAIT_AVAIL; async reset asserted between edges -> no strobe, outputs cleared per REQ-028 before next edge.
